// File: rtl/montgomery_mul.sv
// Bit-serial Montgomery multiplier: o_out = A*B*2^-N mod M, one multiplier bit per cycle.
// Handshaked request/response; one operation in flight, N+3 cycles per operation.
module montgomery_mul #(
    parameter int MOD_WIDTH = 256
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_valid,
    output logic                 i_ready,
    input  logic [MOD_WIDTH-1:0] i_a,
    input  logic [MOD_WIDTH-1:0] i_b,
    input  logic [MOD_WIDTH-1:0] i_modulus,
    output logic                 o_valid,
    input  logic                 o_ready,
    output logic [MOD_WIDTH-1:0] o_out
);
    localparam int CW = (MOD_WIDTH > 1) ? $clog2(MOD_WIDTH) : 1;
    localparam int RW = MOD_WIDTH + 2;
    localparam logic [CW-1:0] LAST = CW'(MOD_WIDTH - 1);

    typedef enum logic [1:0] {IDLE, LOOP, FINAL, HOLD} state_t;

    state_t               state, state_nxt;
    logic [MOD_WIDTH-1:0] a_q, b_q, m_q;
    logic [RW-1:0]        r_q;
    logic [CW-1:0]        cnt;

    logic [RW-1:0] m_ext, t_add, t_red, r_iter, r_fin;

    // Two guard bits keep R + B + M below 2^(N+2) for in-range operands.
    always_comb begin
        m_ext  = {2'b00, m_q};
        t_add  = r_q + (a_q[cnt] ? {2'b00, b_q} : '0);
        t_red  = t_add + (t_add[0] ? m_ext : '0);
        r_iter = t_red >> 1;
        r_fin  = (r_q >= m_ext) ? (r_q - m_ext) : r_q;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        i_ready   = 1'b0;
        o_valid   = 1'b0;
        case (state)
            IDLE: begin
                i_ready = 1'b1;
                if (i_valid) state_nxt = LOOP;
            end
            LOOP:  if (cnt == LAST) state_nxt = FINAL;
            FINAL: state_nxt = HOLD;
            HOLD: begin
                o_valid = 1'b1;
                if (o_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_q <= '0;
            b_q <= '0;
            m_q <= '0;
            r_q <= '0;
            cnt <= '0;
        end else begin
            case (state)
                IDLE: if (i_valid) begin
                    a_q <= i_a;
                    b_q <= i_b;
                    m_q <= i_modulus;
                    r_q <= '0;
                    cnt <= '0;
                end
                LOOP: begin
                    r_q <= r_iter;
                    if (cnt != LAST) cnt <= cnt + CW'(1);
                end
                FINAL:   r_q <= r_fin;
                default: ;
            endcase
        end
    end

    assign o_out = r_q[MOD_WIDTH-1:0];

endmodule
